// File: rtl/seq_divider_16bit_pkg.sv
// Shared definitions for the sequential 16-bit restoring divider:
// FSM state encoding, operand width and the divide-by-zero result constant.
package seq_divider_16bit_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  // Index of the final iteration; one quotient bit is resolved per CALC cycle.
  localparam logic [3:0] LAST_COUNT = 4'd15;

  localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = 16'hFFFF;

endpackage

// File: rtl/seq_divider_16bit_cla.sv
// CLA_16bit_LookAheadUnit: 16-bit carry-lookahead adder built from four 4-bit
// groups with a second-level group-carry lookahead; the divider drives it as a subtractor.
module CLA_16bit_LookAheadUnit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] gen;
  logic [15:0] prop;
  logic [3:0]  grp_gen;
  logic [3:0]  grp_prop;
  logic [4:0]  grp_carry;

  assign gen  = a & b;
  assign prop = a ^ b;

  always_comb begin
    grp_gen  = '0;
    grp_prop = '0;
    for (int k = 0; k < 4; k++) begin
      grp_gen[k]  = gen[4*k+3]
                  | (prop[4*k+3] & gen[4*k+2])
                  | (prop[4*k+3] & prop[4*k+2] & gen[4*k+1])
                  | (prop[4*k+3] & prop[4*k+2] & prop[4*k+1] & gen[4*k]);
      grp_prop[k] = prop[4*k+3] & prop[4*k+2] & prop[4*k+1] & prop[4*k];
    end
  end

  // Group carries are fully expanded so no carry depends on another carry.
  assign grp_carry[0] = cin;
  assign grp_carry[1] = grp_gen[0] | (grp_prop[0] & cin);
  assign grp_carry[2] = grp_gen[1] | (grp_prop[1] & grp_gen[0])
                      | (grp_prop[1] & grp_prop[0] & cin);
  assign grp_carry[3] = grp_gen[2] | (grp_prop[2] & grp_gen[1])
                      | (grp_prop[2] & grp_prop[1] & grp_gen[0])
                      | (grp_prop[2] & grp_prop[1] & grp_prop[0] & cin);
  assign grp_carry[4] = grp_gen[3] | (grp_prop[3] & grp_gen[2])
                      | (grp_prop[3] & grp_prop[2] & grp_gen[1])
                      | (grp_prop[3] & grp_prop[2] & grp_prop[1] & grp_gen[0])
                      | (grp_prop[3] & grp_prop[2] & grp_prop[1] & grp_prop[0] & cin);

  always_comb begin
    logic carry;
    sum   = '0;
    carry = 1'b0;
    for (int k = 0; k < 4; k++) begin
      carry = grp_carry[k];
      for (int j = 0; j < 4; j++) begin
        sum[4*k+j] = prop[4*k+j] ^ carry;
        carry      = gen[4*k+j] | (prop[4*k+j] & carry);
      end
    end
  end

  assign cout = grp_carry[4];

endmodule

// File: rtl/seq_divider_16bit.sv
// Multi-cycle unsigned 16-bit restoring divider: one quotient bit per cycle,
// trial subtraction done by the shared CLA in subtract mode.
module seq_divider_16bit
  import seq_divider_16bit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_t state;
  div_state_t state_next;

  logic [WIDTH:0]   part_rem;
  logic [WIDTH-1:0] quo_sh;
  logic [WIDTH-1:0] divisor_q;
  logic [3:0]       count;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             sub_cout;
  logic             trial_ok;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;
  logic             can_accept;
  logic             last_iter;

  assign can_accept = (state == S_IDLE) || (state == S_DONE);
  assign last_iter  = (count == LAST_COUNT);

  // Shift the next dividend bit into the partial remainder, then try R - D.
  assign shifted = {part_rem[WIDTH-1:0], quo_sh[WIDTH-1]};

  CLA_16bit_LookAheadUnit u_sub (
    .a    (shifted[WIDTH-1:0]),
    .b    (~divisor_q),
    .cin  (1'b1),
    .sum  (diff),
    .cout (sub_cout)
  );

  // A set bit 16 means the shifted value already exceeds any 16-bit divisor.
  assign trial_ok = shifted[WIDTH] | sub_cout;
  assign rem_next = trial_ok ? {1'b0, diff} : shifted;
  assign quo_next = {quo_sh[WIDTH-2:0], trial_ok};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = (divisor == '0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (last_iter) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          state_next = (divisor == '0) ? S_DONE : S_CALC;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath and result registers; results move only on completion or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      part_rem    <= '0;
      quo_sh      <= '0;
      divisor_q   <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (can_accept && start) begin
      part_rem  <= '0;
      quo_sh    <= dividend;
      divisor_q <= divisor;
      count     <= '0;
      if (divisor == '0) begin
        quotient    <= DBZ_QUOTIENT;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        div_by_zero <= 1'b0;
      end
    end else if (state == S_CALC) begin
      part_rem <= rem_next;
      quo_sh   <= quo_next;
      count    <= count + 4'd1;
      if (last_iter) begin
        quotient  <= quo_next;
        remainder <= rem_next[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_seq_divider_16bit.sv
// Scoreboard bench for seq_divider_16bit: the driver pushes expected results
// computed with plain / and %, a negedge monitor pops and compares on each done.
module tb_seq_divider_16bit;

  typedef struct {
    logic [15:0] quo;
    logic [15:0] rem;
    logic        dbz;
    int          exp_edge;
  } expect_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  expect_t     sb_q[$];
  int          errors;
  int          checks;
  int          edge_count;
  logic [15:0] held_quo;
  logic [15:0] held_rem;

  seq_divider_16bit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edge_count = 0;
  always @(posedge clk) edge_count <= edge_count + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at edge %0d",
               name, actual, actual, required, required, edge_count);
    end
  endtask

  function automatic expect_t refModel(input logic [15:0] a, input logic [15:0] b, input int accept_edge);
    expect_t e;
    if (b == 16'd0) begin
      e.quo      = 16'hFFFF;
      e.rem      = a;
      e.dbz      = 1'b1;
      e.exp_edge = accept_edge;
    end else begin
      e.quo      = 16'(int'(a) / int'(b));
      e.rem      = 16'(int'(a) % int'(b));
      e.dbz      = 1'b0;
      e.exp_edge = accept_edge + 16;
    end
    return e;
  endfunction

  // Monitor: compares each done against the oldest expectation and checks that
  // results stay frozen between completions.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      held_quo = 16'd0;
      held_rem = 16'd0;
    end else if (done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done=1, expected no pending result at edge %0d", edge_count);
      end else begin
        expect_t e;
        e = sb_q.pop_front();
        checkOutput("quotient", 32'(quotient), 32'(e.quo));
        checkOutput("remainder", 32'(remainder), 32'(e.rem));
        checkOutput("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
        checkOutput("latency_edge", 32'(edge_count), 32'(e.exp_edge));
        checkOutput("busy_in_done", 32'(busy), 32'd0);
        held_quo = e.quo;
        held_rem = e.rem;
      end
    end else if (edge_count > 3) begin
      checkOutput("quotient_held", 32'(quotient), 32'(held_quo));
      checkOutput("remainder_held", 32'(remainder), 32'(held_rem));
    end
  end

  // Presents one request; returns at the negedge following the accepting edge.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    sb_q.push_back(refModel(a, b, edge_count + 1));
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom();
    divisor  = $urandom();
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got no done within 40 cycles, expected %0d pending result(s)", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic pulseReset();
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_quotient", 32'(quotient), 32'd0);
    checkOutput("rst_remainder", 32'(remainder), 32'd0);
    checkOutput("rst_div_by_zero", 32'(div_by_zero), 32'd0);
    #1 rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    logic [15:0] a;
    logic [15:0] b;
    errors   = 0;
    checks   = 0;
    held_quo = 16'd0;
    held_rem = 16'd0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = 16'd0;
    divisor  = 16'd0;
    repeat (3) @(negedge clk);
    pulseReset();

    // 100/7: busy for exactly 16 cycles, then a done pulse.
    applyStimulus(16'd100, 16'd7);
    for (int i = 0; i < 16; i++) begin
      checkOutput("busy_calc", 32'(busy), 32'd1);
      @(negedge clk);
    end
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("busy_after", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(done), 32'd0);

    applyStimulus(16'hFFFF, 16'h8000); waitDone();
    applyStimulus(16'hFFFF, 16'd1);    waitDone();
    applyStimulus(16'd3, 16'd10);      waitDone();
    applyStimulus(16'd5, 16'd0);       waitDone();

    // 1000/3 with start held and operands changed mid-CALC; 9/9 is taken in the done cycle.
    @(negedge clk);
    base     = edge_count;
    start    = 1'b1;
    dividend = 16'd1000;
    divisor  = 16'd3;
    sb_q.push_back(refModel(16'd1000, 16'd3, base + 1));
    @(negedge clk);
    dividend = 16'd9;
    divisor  = 16'd9;
    while (edge_count < base + 18) @(negedge clk);
    sb_q.push_back(refModel(16'd9, 16'd9, base + 18));
    checkOutput("b2b_busy", 32'(busy), 32'd1);
    start = 1'b0;
    waitDone();

    // Abort 5 cycles into CALC; no done may follow.
    applyStimulus(16'd50000, 16'd7);
    repeat (4) @(negedge clk);
    pulseReset();
    repeat (25) @(negedge clk);
    applyStimulus(16'd20, 16'd4); waitDone();

    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom());
      if (($urandom() % 4) == 0) b = 16'($urandom_range(15, 1));
      else b = 16'($urandom_range(65535, 1));
      applyStimulus(a, b);
      waitDone();
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_divider_16bit.md
Name: seq_divider_16bit

Overview:
Multi-cycle unsigned 16-bit restoring divider for the miniRISC ALU. It is the inverse-direction partner of the registered 16-bit CLA adder, and runs the existing CLA_16bit_LookAheadUnit in subtract mode (operand B inverted, carry-in 1).
- Operands are captured on a start handshake.
- One quotient bit is produced per cycle.
- Quotient and remainder are held with a one-cycle done pulse.

Parameters:
WIDTH, 16, operand/result width. Only 16 is supported because the CLA instance is fixed 16-bit; other values are out of scope.

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  reset
start  input  1  request a division; sampled only when idle or in the done cycle
dividend  input  16  numerator, captured when start is accepted
divisor  input  16  denominator, captured when start is accepted
busy  output  1  high while iterating
done  output  1  one-cycle pulse when results become valid
quotient  output  16  result quotient, held until next accepted start
remainder  output  16  result remainder, held until next accepted start
div_by_zero  output  1  set with done when captured divisor was 0; held with results

Behaviour:
- Reset: one clock (clk); reset (rst) is synchronous and active-high.
  - rst high at a posedge forces state IDLE.
  - busy=0, done=0, quotient=16'd0, remainder=16'd0, div_by_zero=0.
  - Internal counter, shift registers and captured operands all clear.
  - rst overrides start.
  - rst mid-operation aborts the division; no done is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 and divisor!=0: capture operands; partial remainder R (17-bit)=0; Q=dividend; count=0; go to CALC; clear div_by_zero.
  - start=1 and divisor==0: go to DONE with quotient=16'hFFFF, remainder=dividend, div_by_zero=1.
- CALC (busy=1), per cycle:
  - S = {R[15:0], Q[15]}, Q shifted left by 1.
  - Subtract S[15:0] - divisor via CLA (~divisor, cin=1), giving diff and cout.
  - Trial succeeds iff S[16]==1 or cout==1. On success: R={1'b0,diff}, Q[0]=1. Otherwise: R=S, Q[0]=0.
  - count increments. After the iteration with count==15, load quotient=Q and remainder=R[15:0], then go to DONE.
- DONE: done=1 for exactly one cycle, busy=0.
  - start=1 in this cycle is accepted exactly as in IDLE (back-to-back issue allowed).
  - Otherwise go to IDLE.
- Latency: start accepted at edge N gives done high in the cycle after edge N+16 (17 cycles, start to done). The divide-by-zero path gives done after 1 cycle.
- start during CALC is ignored; captured operands must not change.
- Input changes after acceptance have no effect.
- Outputs quotient, remainder and div_by_zero change only when done is asserted (or on reset).
- No signed support; no overflow case other than divide-by-zero.

Decomposition:
- Shared package/header: state encodings (S_IDLE=2'd0, S_CALC=2'd1, S_DONE=2'd2), WIDTH, and the divide-by-zero quotient constant 16'hFFFF.
- Sub-module: reuse CLA_16bit_LookAheadUnit (included from the adder directory) as the subtractor. No new sub-module.
- The datapath (R/Q/count registers) and the FSM live in the one module.

Test Plan:
- 100/7, start pulse in IDLE -> busy for 16 cycles; done pulse 17 cycles after accept; quotient=14, remainder=2, div_by_zero=0.
- 16'hFFFF/16'h8000 (exercises the S[16] path) -> quotient=1, remainder=16'h7FFF. Then 16'hFFFF/1 -> quotient=16'hFFFF, remainder=0.
- 3/10 -> quotient=0, remainder=3. Then 5/0 -> done after 1 cycle, quotient=16'hFFFF, remainder=5, div_by_zero=1.
- Start 1000/3; hold start high with new operands 9/9 during CALC -> ignored; result quotient=333, remainder=1. Start asserted in the done cycle with 9/9 -> accepted; next result quotient=1, remainder=0.
- Assert rst 5 cycles into CALC -> next cycle busy=0, done=0, all outputs 0. No done pulse follows. A fresh 20/4 then yields quotient=5, remainder=0.
- Random sweep of 1000 pairs (divisor!=0) against a reference model -> quotient=a/b, remainder=a%b, latency always 17.
